// File: rtl/mark_pkg.sv
// Shared constants and width helpers for the mark history engine.
package mark_pkg;

  localparam logic [1:0] NAK_NONE   = 2'd0;
  localparam logic [1:0] NAK_POS    = 2'd1;
  localparam logic [1:0] NAK_PLAYER = 2'd2;
  localparam logic [1:0] NAK_OCC    = 2'd3;

  // clog2 that never returns zero, so a 1-entry range still gets a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2_min1(depth + 1);
  endfunction

endpackage

// File: rtl/mark_ring.sv
// Per-player history FIFO: push appends, push while full overwrites the oldest slot.
module mark_ring
  import mark_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned PW    = 4,
  parameter int unsigned CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [PW-1:0] i_data,
  output logic [CW-1:0] o_count,
  output logic [PW-1:0] o_oldest,
  output logic          o_full
);

  localparam int unsigned AW = clog2_min1(DEPTH);

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_full;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign o_full   = w_full;
  assign o_count  = r_count;
  assign o_oldest = r_mem[r_tail];

  // Ring storage and pointers; when full, head and tail coincide so the write lands on the oldest slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_mem[r_head] <= i_data;
      r_head        <= next_ptr(r_head);
      if (w_full) r_tail  <= next_ptr(r_tail);
      else        r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/mark_history_engine.sv
// Board occupancy with a bounded per-player mark history; oldest mark fades on overflow.
module mark_history_engine
  import mark_pkg::*;
#(
  parameter  int unsigned CELLS   = 9,
  parameter  int unsigned PLAYERS = 2,
  parameter  int unsigned DEPTH   = 3,
  localparam int unsigned PW      = clog2_min1(CELLS),
  localparam int unsigned IW      = clog2_min1(PLAYERS),
  localparam int unsigned CW      = cnt_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     move_valid,
  input  logic [IW-1:0]            move_player,
  input  logic [PW-1:0]            move_pos,
  output logic [PLAYERS*CELLS-1:0] grid,
  output logic                     move_ack,
  output logic                     move_nak,
  output logic [1:0]               nak_code,
  output logic [PLAYERS*CW-1:0]    mark_count,
  output logic [PLAYERS*PW-1:0]    fade_pos,
  output logic [PLAYERS-1:0]       fade_valid
);

  localparam int unsigned GW     = clog2_min1(PLAYERS * CELLS);
  localparam int unsigned NSLOTS = 1 << PW;

  logic [PLAYERS*CELLS-1:0]       r_grid;
  logic                           r_ack;
  logic                           r_nak;
  logic [1:0]                     r_nak_code;

  logic [NSLOTS-1:0]              w_col_occ;
  logic                           w_eval;
  logic                           w_accept;
  logic [1:0]                     w_code;
  logic [PLAYERS-1:0]             w_push;
  logic [PLAYERS-1:0]             w_full;
  logic [PLAYERS-1:0][PW-1:0]     w_oldest;
  logic [PLAYERS-1:0][CW-1:0]     w_count;
  logic [PLAYERS*CELLS-1:0]       w_grid_nxt;

  assign w_eval = move_valid && enable && !clear;

  // Column occupancy: a cell is taken if any player holds it; unused slots read as free.
  always_comb begin
    w_col_occ = '0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      for (int c = 0; c < int'(CELLS); c++) begin
        w_col_occ[PW'(c)] = w_col_occ[PW'(c)] | r_grid[GW'(p * int'(CELLS) + c)];
      end
    end
  end

  // Priority-ordered move checks and per-player push decode.
  always_comb begin
    w_code = NAK_NONE;
    if (32'(move_pos) >= CELLS)         w_code = NAK_POS;
    else if (32'(move_player) >= PLAYERS) w_code = NAK_PLAYER;
    else if (w_col_occ[move_pos])       w_code = NAK_OCC;
    w_accept = w_eval && (w_code == NAK_NONE);
    for (int p = 0; p < int'(PLAYERS); p++) begin
      w_push[p] = w_accept && (move_player == IW'(p));
    end
  end

  // Next grid: drop the mover's fading mark (if full) and set the new mark in one edge.
  always_comb begin
    w_grid_nxt = r_grid;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      if (w_push[p]) begin
        if (w_full[p]) w_grid_nxt[GW'(p * int'(CELLS)) + GW'(w_oldest[p])] = 1'b0;
        w_grid_nxt[GW'(p * int'(CELLS)) + GW'(move_pos)] = 1'b1;
      end
    end
  end

  // Grid and handshake registers; clear wins over any move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grid     <= '0;
      r_ack      <= 1'b0;
      r_nak      <= 1'b0;
      r_nak_code <= NAK_NONE;
    end else if (clear) begin
      r_grid     <= '0;
      r_ack      <= 1'b0;
      r_nak      <= 1'b0;
      r_nak_code <= NAK_NONE;
    end else begin
      r_grid     <= w_grid_nxt;
      r_ack      <= w_accept;
      r_nak      <= w_eval && (w_code != NAK_NONE);
      r_nak_code <= w_eval ? w_code : NAK_NONE;
    end
  end

  assign grid     = r_grid;
  assign move_ack = r_ack;
  assign move_nak = r_nak;
  assign nak_code = r_nak_code;

  // One history ring per player; outputs packed into the flat per-player buses.
  for (genvar g = 0; g < int'(PLAYERS); g++) begin : g_player
    mark_ring #(
      .DEPTH (DEPTH),
      .PW    (PW),
      .CW    (CW)
    ) u_ring (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (clear),
      .i_push   (w_push[g]),
      .i_data   (move_pos),
      .o_count  (w_count[g]),
      .o_oldest (w_oldest[g]),
      .o_full   (w_full[g])
    );

    assign mark_count[g*CW +: CW] = w_count[g];
    assign fade_valid[g]          = w_full[g];
    assign fade_pos[g*PW +: PW]   = w_full[g] ? w_oldest[g] : '0;
  end

endmodule

// File: tb/tb_mark_history_engine.sv
// Directed and model-checked bench for mark_history_engine.
module tb_mark_history_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default configuration: 9 cells, 2 players, depth 3.
  logic        a_en, a_clr, a_mv;
  logic [0:0]  a_pl;
  logic [3:0]  a_pos;
  logic [17:0] a_grid;
  logic        a_ack, a_nak;
  logic [1:0]  a_code;
  logic [3:0]  a_cnt;
  logic [7:0]  a_fpos;
  logic [1:0]  a_fval;

  // Three players on 9 cells, depth 2.
  logic        b_en, b_clr, b_mv;
  logic [1:0]  b_pl;
  logic [3:0]  b_pos;
  logic [26:0] b_grid;
  logic        b_ack, b_nak;
  logic [1:0]  b_code;
  logic [5:0]  b_cnt;
  logic [11:0] b_fpos;
  logic [2:0]  b_fval;

  // Four players on 16 cells, depth 2.
  logic        c_en, c_clr, c_mv;
  logic [1:0]  c_pl;
  logic [3:0]  c_pos;
  logic [63:0] c_grid;
  logic        c_ack, c_nak;
  logic [1:0]  c_code;
  logic [7:0]  c_cnt;
  logic [15:0] c_fpos;
  logic [3:0]  c_fval;

  mark_history_engine u_dut_a (
    .clk(clk), .reset(reset), .enable(a_en), .clear(a_clr), .move_valid(a_mv),
    .move_player(a_pl), .move_pos(a_pos), .grid(a_grid), .move_ack(a_ack),
    .move_nak(a_nak), .nak_code(a_code), .mark_count(a_cnt), .fade_pos(a_fpos),
    .fade_valid(a_fval)
  );

  mark_history_engine #(.CELLS(9), .PLAYERS(3), .DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset), .enable(b_en), .clear(b_clr), .move_valid(b_mv),
    .move_player(b_pl), .move_pos(b_pos), .grid(b_grid), .move_ack(b_ack),
    .move_nak(b_nak), .nak_code(b_code), .mark_count(b_cnt), .fade_pos(b_fpos),
    .fade_valid(b_fval)
  );

  mark_history_engine #(.CELLS(16), .PLAYERS(4), .DEPTH(2)) u_dut_c (
    .clk(clk), .reset(reset), .enable(c_en), .clear(c_clr), .move_valid(c_mv),
    .move_player(c_pl), .move_pos(c_pos), .grid(c_grid), .move_ack(c_ack),
    .move_nak(c_nak), .nak_code(c_code), .mark_count(c_cnt), .fade_pos(c_fpos),
    .fade_valid(c_fval)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_a(input logic [0:0] p, input logic [3:0] pos);
    a_pl  = p;
    a_pos = pos;
    a_mv  = 1'b1;
    tick();
    a_mv  = 1'b0;
  endtask

  // Reference model for the 4-player instance.
  int          hist [4][2];
  int          mc   [4];
  logic [63:0] mg;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          p, pos, tries;
    logic        occ;
    logic [7:0]  exp_cnt;

    reset = 1'b0;
    a_en = 0; a_clr = 0; a_mv = 0; a_pl = '0; a_pos = '0;
    b_en = 0; b_clr = 0; b_mv = 0; b_pl = '0; b_pos = '0;
    c_en = 0; c_clr = 0; c_mv = 0; c_pl = '0; c_pos = '0;
    #2;
    check("rst_grid", 64'(a_grid), 64'h0);
    check("rst_ack",  64'(a_ack),  64'h0);
    check("rst_nak",  64'(a_nak),  64'h0);
    check("rst_code", 64'(a_code), 64'h0);
    check("rst_cnt",  64'(a_cnt),  64'h0);
    check("rst_fpos", 64'(a_fpos), 64'h0);
    check("rst_fval", 64'(a_fval), 64'h0);
    tick(); tick();
    reset = 1'b1;
    a_en = 1; b_en = 1; c_en = 1;
    tick();

    // Fill P0 to depth.
    move_a(1'b0, 4'd0);
    check("p0_0_ack", 64'(a_ack), 64'h1);
    check("p0_0_grid", 64'(a_grid), 64'h1);
    move_a(1'b0, 4'd1);
    move_a(1'b0, 4'd2);
    check("p0_2_ack",  64'(a_ack),  64'h1);
    check("full_grid", 64'(a_grid), 64'h7);
    check("full_cnt",  64'(a_cnt),  64'h3);
    check("full_fval", 64'(a_fval), 64'h1);
    check("full_fpos", 64'(a_fpos), 64'h0);

    // Overflow: cell 0 fades, 5 appears in the same edge.
    move_a(1'b0, 4'd5);
    check("ovf_ack",  64'(a_ack),  64'h1);
    check("ovf_grid", 64'(a_grid), 64'h26);
    check("ovf_fpos", 64'(a_fpos), 64'h01);
    check("ovf_cnt",  64'(a_cnt),  64'h3);

    // Rejections.
    move_a(1'b1, 4'd5);
    check("occ_nak",  64'(a_nak),  64'h1);
    check("occ_ack",  64'(a_ack),  64'h0);
    check("occ_code", 64'(a_code), 64'h3);
    check("occ_grid", 64'(a_grid), 64'h26);
    move_a(1'b0, 4'd9);
    check("pos_nak",  64'(a_nak),  64'h1);
    check("pos_code", 64'(a_code), 64'h1);
    move_a(1'b0, 4'd1);
    check("fade_nak",  64'(a_nak),  64'h1);
    check("fade_code", 64'(a_code), 64'h3);
    check("fade_grid", 64'(a_grid), 64'h26);
    move_a(1'b0, 4'd0);
    check("refill_ack",  64'(a_ack),  64'h1);
    check("refill_grid", 64'(a_grid), 64'h25);
    check("refill_fpos", 64'(a_fpos), 64'h02);
    tick();
    check("idle_ack", 64'(a_ack), 64'h0);
    check("idle_nak", 64'(a_nak), 64'h0);

    // Disabled game ignores moves.
    a_en = 0;
    move_a(1'b1, 4'd7);
    check("dis_ack",  64'(a_ack),  64'h0);
    check("dis_nak",  64'(a_nak),  64'h0);
    check("dis_grid", 64'(a_grid), 64'h25);
    a_en = 1;

    // Other player's move leaves P0 intact.
    move_a(1'b1, 4'd3);
    check("p1_ack",  64'(a_ack),  64'h1);
    check("p1_grid", 64'(a_grid), 64'h1025);
    check("p1_cnt",  64'(a_cnt),  64'h7);
    check("p1_fval", 64'(a_fval), 64'h1);

    // Clear beats a simultaneous move.
    a_clr = 1;
    move_a(1'b1, 4'd8);
    a_clr = 0;
    check("clr_ack",  64'(a_ack),  64'h0);
    check("clr_nak",  64'(a_nak),  64'h0);
    check("clr_grid", 64'(a_grid), 64'h0);
    check("clr_cnt",  64'(a_cnt),  64'h0);
    check("clr_fval", 64'(a_fval), 64'h0);
    check("clr_fpos", 64'(a_fpos), 64'h0);
    move_a(1'b0, 4'd4);
    check("post_clr_grid", 64'(a_grid), 64'h10);
    check("post_clr_cnt",  64'(a_cnt),  64'h1);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    check("async_grid", 64'(a_grid), 64'h0);
    check("async_cnt",  64'(a_cnt),  64'h0);
    check("async_ack",  64'(a_ack),  64'h0);
    tick();
    reset = 1'b1;
    tick();

    // Bad player on the 3-player instance, and position priority over player.
    b_pl = 2'd3; b_pos = 4'd0; b_mv = 1;
    tick();
    check("bply_nak",  64'(b_nak),  64'h1);
    check("bply_code", 64'(b_code), 64'h2);
    check("bply_grid", 64'(b_grid), 64'h0);
    b_pos = 4'd9;
    tick();
    check("bpri_code", 64'(b_code), 64'h1);
    b_pl = 2'd2; b_pos = 4'd8;
    tick();
    b_mv = 0;
    check("b_p2_ack",  64'(b_ack),  64'h1);
    check("b_p2_grid", 64'(b_grid), 64'h1 << 26);

    // Random legal moves on the 4-player instance against a queue model.
    mg = '0;
    for (int q = 0; q < 4; q++) mc[q] = 0;
    for (int k = 0; k < 20; k++) begin
      p     = int'($urandom_range(0, 3));
      pos   = 0;
      tries = 0;
      occ   = 1'b1;
      while (occ && tries < 1000) begin
        pos = int'($urandom_range(0, 15));
        occ = 1'b0;
        for (int q = 0; q < 4; q++) occ = occ | mg[q*16 + pos];
        tries++;
      end
      if (mc[p] == 2) begin
        mg[p*16 + hist[p][0]] = 1'b0;
        hist[p][0] = hist[p][1];
        hist[p][1] = pos;
      end else begin
        hist[p][mc[p]] = pos;
        mc[p]++;
      end
      mg[p*16 + pos] = 1'b1;
      for (int q = 0; q < 4; q++) exp_cnt[q*2 +: 2] = 2'(mc[q]);

      c_pl = 2'(p); c_pos = 4'(pos); c_mv = 1;
      tick();
      c_mv = 0;
      check("rnd_ack",  64'(c_ack),  64'h1);
      check("rnd_grid", c_grid,      mg);
      check("rnd_cnt",  64'(c_cnt),  64'(exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mark_history_engine.md
MARK_HISTORY_ENGINE -- requirements
Module: mark_history_engine

Interface
REQ-001 Parameter CELLS, default 9: number of board cells, range 4..64.
REQ-002 Parameter PLAYERS, default 2: number of players, range 2..4.
REQ-003 Parameter DEPTH, default 3: maximum live marks per player, range 1..8, with DEPTH*PLAYERS < CELLS.
REQ-004 Derived widths: PW = clog2(CELLS), IW = clog2(PLAYERS) (minimum 1), CW = clog2(DEPTH+1).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  game running; moves are ignored while low.
REQ-008 clear  in  1  synchronous board/history clear; takes priority over any move.
REQ-009 move_valid  in  1  move request this cycle.
REQ-010 move_player  in  IW  requesting player index.
REQ-011 move_pos  in  PW  target cell.
REQ-012 grid  out  PLAYERS*CELLS  occupancy; bit p*CELLS+c is set when player p holds cell c.
REQ-013 move_ack  out  1  one-cycle pulse: the move was accepted.
REQ-014 move_nak  out  1  one-cycle pulse: the move was rejected.
REQ-015 nak_code  out  2  reject reason, valid with move_nak: 1 = bad position, 2 = bad player, 3 = cell occupied.
REQ-016 mark_count  out  PLAYERS*CW  live marks per player; field p holds player p.
REQ-017 fade_pos  out  PLAYERS*PW  per player, the cell that disappears on that player's next accepted move; valid only when the count equals DEPTH, otherwise 0.
REQ-018 fade_valid  out  PLAYERS  per player, set when the count equals DEPTH.

Function
REQ-019 A move is evaluated only when move_valid, enable and !clear are all high; at most one move per cycle.
REQ-020 Checks in priority order: move_pos >= CELLS gives code 1; move_player >= PLAYERS gives code 2; the cell held by any player gives code 3. Any failed check causes a nak and no state change.
REQ-021 Accepted move: set the grid bit, push move_pos onto the player's history ring, and pulse move_ack. All take effect at the next rising edge (latency 1).
REQ-022 Count below DEPTH: the accepted move appends and increments the count.
REQ-023 Count equal to DEPTH: in the same cycle, the accepted move clears the oldest cell's grid bit, overwrites that oldest slot, and leaves the count unchanged.
REQ-024 A move onto the player's own fade_pos cell is rejected with code 3; the cell is still occupied when the check is made.
REQ-025 Only the mover's history changes; other players' marks never disappear on another player's move.
REQ-026 History ring: head/tail pointers wrap at DEPTH; order is strictly FIFO.
REQ-027 move_ack and move_nak are mutually exclusive and low when no move is evaluated; enable low plus move_valid gives neither.
REQ-028 clear: at the next edge, grid, all counts and all pointers go to 0, and ack/nak are low that cycle.
REQ-029 Outputs are registered; fade_pos and fade_valid derive from registered ring state only.

Reset
REQ-030 While reset is low: grid = 0, move_ack = 0, move_nak = 0, nak_code = 0, mark_count = 0, fade_pos = 0, fade_valid = 0, all history storage and pointers = 0.
REQ-031 Reset is asserted asynchronously and released synchronously by the clk domain in the enclosing system; a move in flight when reset asserts is lost.

Structure
REQ-032 The shared package mark_pkg holds the nak_code constants (NAK_NONE, NAK_POS, NAK_PLAYER, NAK_OCC) and the clog2-based width helpers.
REQ-033 One sub-module, mark_ring, is instantiated PLAYERS times: a DEPTH-entry PW-wide FIFO with push, push-while-full-overwrite, clear, count, and oldest outputs.
REQ-034 Occupancy check and grid update stay in the top level; total size is 120-400 RTL lines.

Verification
REQ-035 Defaults: P0 plays 0,1,2 -> three acks, mark_count[0] = 3, fade_valid[0] = 1, fade_pos[0] = 0.
REQ-036 Continuing, P0 plays 5 -> ack; grid bit 0 clears and bit 5 sets in one edge; fade_pos[0] = 1; count stays 3.
REQ-037 P1 plays cell 5 while P0 holds it -> nak, code 3; grid unchanged. move_pos = 9 -> code 1. PLAYERS = 3 with move_player = 3 -> code 2.
REQ-038 P0 full at {0,1,2}, then P0 plays 0 -> nak code 3; then P0 plays 3 -> grid bit 0 clears.
REQ-039 clear and move_valid asserted in the same cycle -> no ack/nak; grid = 0 and counts = 0 next edge. Reset pulsed mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
REQ-040 CELLS = 16, PLAYERS = 4, DEPTH = 2: 20 random legal moves -> every player holds at most 2 marks, and grid matches the reference queue model every cycle.
